// File: rtl/imem_read_responder.sv
// Word-addressed memory that answers a single outstanding read after a fixed latency,
// with flush abort and a byte-masked write port for image loading and stores.
module imem_read_responder #(
    parameter int XLEN           = 32,
    parameter int READ_ADDR_SIZE = 32,
    parameter int DEPTH_LOG2     = 10,
    parameter int READ_LATENCY   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_readEn,
    input  logic [READ_ADDR_SIZE-1:0] mem_read_addr,
    input  logic                      flush,
    input  logic                      wrEn,
    input  logic [READ_ADDR_SIZE-1:0] wrAddr,
    input  logic [XLEN-1:0]           wrData,
    input  logic [XLEN/8-1:0]         wrMask,
    output logic [XLEN-1:0]           mem_read_data,
    output logic                      readFin,
    output logic                      misalign,
    output logic                      busy,
    output logic [1:0]                state_dbg
);

    if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_latency
        $error("imem_read_responder: READ_LATENCY must be in 1..15");
    end

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] LOAD_CNT = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: a request is accepted when mem_readEn=1 and flush=0 in IDLE; the
    // result is presented for exactly one cycle with readFin=1, no back-pressure.
    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  capture;
    logic                  accept;

    logic [XLEN-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0] req_idx, wr_idx, lat_idx_q, cap_idx;
    logic                  lat_mis_q, cap_mis;

    assign req_idx = mem_read_addr[DEPTH_LOG2+1:2];
    assign wr_idx  = wrAddr[DEPTH_LOG2+1:2];
    assign accept  = (state_q == IDLE) && mem_readEn && !flush;

    // With a latency of one the capture edge is the acceptance edge, so index from the live address.
    assign cap_idx = (state_q == IDLE) ? req_idx : lat_idx_q;
    assign cap_mis = (state_q == IDLE) ? (mem_read_addr[1:0] != 2'b00) : lat_mis_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_read_addr[READ_ADDR_SIZE-1:DEPTH_LOG2+2],
                                wrAddr[READ_ADDR_SIZE-1:DEPTH_LOG2+2], wrAddr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_readEn) begin
                        if (READ_LATENCY == 1) begin
                            state_d = DONE;
                            capture = 1'b1;
                        end else begin
                            state_d = BUSY;
                            cnt_d   = LOAD_CNT;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q <= 4'd1) begin
                        state_d = DONE;
                        cnt_d   = 4'd0;
                        capture = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            readFin       <= 1'b0;
            misalign      <= 1'b0;
            mem_read_data <= '0;
            lat_idx_q     <= '0;
            lat_mis_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            readFin  <= capture;
            misalign <= capture && cap_mis;
            if (capture) begin
                mem_read_data <= mem[cap_idx];
            end
            if (accept) begin
                lat_idx_q <= req_idx;
                lat_mis_q <= (mem_read_addr[1:0] != 2'b00);
            end
        end
    end

    // Array is not reset; a same-edge write is not seen by the capture (old word returned).
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int b = 0; b < XLEN / 8; b++) begin
                if (wrMask[b]) begin
                    mem[wr_idx][8*b +: 8] <= wrData[8*b +: 8];
                end
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: doc/imem_read_responder.md
Name: imem_read_responder

Overview:
- Word-addressed instruction/data memory that answers the fetch stage's read handshake (mem_readEn / mem_read_addr in, mem_read_data / readFin out).
- Accepts one read at a time and returns the data after a fixed, parameterised latency.
- Supports pipeline flush so that requests abandoned on redirect never complete.
- A separate byte-masked write port loads program images and serves stores.

Parameters:
XLEN, 32, data word width.
READ_ADDR_SIZE, 32, byte-address width of read and write ports.
DEPTH_LOG2, 10, log2 of memory depth in words (1024 words).
READ_LATENCY, 2, cycles from accepted request to readFin; legal range 1..15.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous reset, active-high.
mem_readEn  input  1  read request level from initiator.
mem_read_addr  input  READ_ADDR_SIZE  byte address of requested word.
flush  input  1  abort any in-flight read (redirect/interrupt).
wrEn  input  1  write strobe.
wrAddr  input  READ_ADDR_SIZE  byte address of write word.
wrData  input  XLEN  write data.
wrMask  input  XLEN/8  byte enables; bit i writes wrData[8i+7:8i].
mem_read_data  output  XLEN  read data; valid only while readFin=1.
readFin  output  1  one-cycle completion pulse.
misalign  output  1  high with readFin if latched addr[1:0]!=0.
busy  output  1  high while a read is outstanding (state BUSY or DONE).

Behaviour:
- Index = addr[DEPTH_LOG2+1:2]. Upper bits are ignored, so addresses wrap modulo depth. addr[1:0] is ignored for indexing and only drives misalign.
- Memory array is not reset. rst forces state IDLE, readFin=0, mem_read_data=0, misalign=0, busy=0, cnt=0.
- FSM states:
  - IDLE: if mem_readEn=1 and flush=0, latch addr, load cnt=READ_LATENCY-1, go to BUSY (or straight to DONE if READ_LATENCY=1).
  - BUSY: decrement cnt each cycle; when cnt reaches 1, go to DONE on the next edge.
  - DONE: on entry edge, register mem_read_data from array[latched index], set readFin=1 and misalign; next edge returns to IDLE, readFin=0.
- Latency: request seen in IDLE in cycle 0 gives readFin high in exactly cycle READ_LATENCY.
- Back-to-back: readFin is registered and held one cycle only. The next request is sampled in the cycle after readFin, so the issue interval is READ_LATENCY+1 cycles.
- Once accepted, a read completes even if mem_readEn drops. The initiator stays waiting on readFin regardless of its own enable.
- mem_read_addr changes after acceptance are ignored.
- flush=1 in any state returns the FSM to IDLE next edge with readFin=0 and no data update. Flush has priority over acceptance and over completion; a flush in the same cycle as the DONE-entry edge suppresses readFin.
- mem_read_data holds its last value when readFin=0, but consumers must not rely on it.
- Writes take effect at the posedge with wrEn=1, per byte per wrMask. wrMask=0 means no change.
- Write/read collision: a write and the read-capture edge to the same index in the same cycle return the OLD word. A write on any earlier edge is visible.
- rst mid-read discards the request: no readFin after reset, even if mem_readEn remains high. A new request is accepted from the first cycle after rst deasserts.
- Parameter check: READ_LATENCY<1 or >15 is a elaboration-time error.

Test Plan:
1. Preload word 0x10 (byte addr 0x40) = 0xDEADBEEF. With READ_LATENCY=2, pulse mem_readEn with addr 0x40 in cycle 0 -> readFin=1 only in cycle 2, mem_read_data=0xDEADBEEF, misalign=0, busy high in cycles 1-2.
2. Hold mem_readEn=1 with addr stepping 0x0, 0x4, 0x8 (contents 1, 2, 3) -> readFin pulses in cycles 2, 5, 8 with data 1, 2, 3. Between pulses readFin=0.
3. Accept a read at 0x40, drop mem_readEn in cycle 1, change addr to 0x80 -> readFin in cycle 2 still returns the 0x40 word.
4. Accept a read, assert flush in cycle 1 -> no readFin, busy=0 by cycle 2. Repeat with flush in the DONE-entry cycle -> readFin never asserts.
5. Write 0x11223344 with wrMask=4'b0101 to word 0x5 (old 0xAAAAAAAA) -> read returns 0xAA22AA44. Write in the same cycle as the capture edge -> old value returned; a subsequent read returns the new value.
6. Read addr 0x1002 with DEPTH_LOG2=10 -> wraps to index 0, misalign=1 with readFin. Assert rst in cycle 1 of a read -> no readFin, all outputs 0.
